// File: rtl/axi_lite_reg_slave.sv
// AXI-lite register slave: NREGS x 32-bit registers, no BRESP/RRESP.
// Define AXI_LITE_REG_SLAVE_RD_PIPE_EN to add one read wait state.
module axi_lite_reg_slave #(
  parameter int          NREGS     = 8,
  parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic [31:0]           s_awaddr,
  input  logic [2:0]            s_awprot,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  input  logic [31:0]           s_wdata,
  input  logic [3:0]            s_wstrb,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  input  logic [31:0]           s_araddr,
  input  logic [2:0]            s_arprot,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  output logic [31:0]           s_rdata,
  output logic [32*NREGS-1:0]   regs_q,
  output logic [NREGS-1:0]      wr_pulse
);

  logic [31:0] regs [NREGS];
  logic        aw_held;
  logic        w_held;
  logic [7:0]  aw_idx;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic        rd_pend;
  logic        aw_hs;
  logic        w_hs;
  logic        ar_hs;
  logic        commit;
  logic [31:0] rd_val;
  logic        unused_bits;

  assign s_awready = resetn && !aw_held && !s_bvalid;
  assign s_wready  = resetn && !w_held && !s_bvalid;
  assign s_arready = resetn && !s_rvalid && !rd_pend;

  assign aw_hs  = s_awvalid && s_awready;
  assign w_hs   = s_wvalid && s_wready;
  assign ar_hs  = s_arvalid && s_arready;
  assign commit = aw_held && w_held;

  assign unused_bits = ^{s_awaddr[31:10], s_awaddr[1:0], s_awprot,
                         s_araddr[31:10], s_araddr[1:0], s_arprot};

  always_comb begin
    rd_val = 32'hDEAD_BEEF;
    for (int i = 0; i < NREGS; i++) begin
      if (s_araddr[9:2] == 8'(i)) rd_val = regs[i];
    end
  end

  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      regs_q[32*i +: 32] = regs[i];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_idx   <= '0;
      w_data   <= '0;
      w_strb   <= '0;
      s_bvalid <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_held <= 1'b1;
        aw_idx  <= s_awaddr[9:2];
      end
      if (w_hs) begin
        w_held <= 1'b1;
        w_data <= s_wdata;
        w_strb <= s_wstrb;
      end
      if (commit) begin
        aw_held  <= 1'b0;
        w_held   <= 1'b0;
        s_bvalid <= 1'b1;
      end else if (s_bvalid && s_bready) begin
        s_bvalid <= 1'b0;
      end
    end
  end

  // Unmapped indices match no register, so they commit as a no-op.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= RESET_VAL;
      wr_pulse <= '0;
    end else begin
      wr_pulse <= '0;
      if (commit) begin
        for (int i = 0; i < NREGS; i++) begin
          if (aw_idx == 8'(i)) begin
            for (int b = 0; b < 4; b++) begin
              if (w_strb[b]) regs[i][8*b +: 8] <= w_data[8*b +: 8];
            end
            if (|w_strb) wr_pulse[i] <= 1'b1;
          end
        end
      end
    end
  end

  // Read data is captured at the AR edge, before any same-edge commit lands.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s_rvalid <= 1'b0;
      s_rdata  <= '0;
      rd_pend  <= 1'b0;
    end else begin
      if (s_rvalid && s_rready) s_rvalid <= 1'b0;
`ifdef AXI_LITE_REG_SLAVE_RD_PIPE_EN
      if (ar_hs) begin
        rd_pend <= 1'b1;
        s_rdata <= rd_val;
      end
      if (rd_pend) begin
        rd_pend  <= 1'b0;
        s_rvalid <= 1'b1;
      end
`else
      rd_pend <= 1'b0;
      if (ar_hs) begin
        s_rvalid <= 1'b1;
        s_rdata  <= rd_val;
      end
`endif
    end
  end

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Randomized bench for axi_lite_reg_slave against an array reference model.
module tb_axi_lite_reg_slave;

  localparam int          N  = 8;
  localparam logic [31:0] RV = 32'h0000_0000;

  logic           clk = 1'b0;
  logic           resetn;
  logic           s_awvalid, s_awready;
  logic [31:0]    s_awaddr;
  logic [2:0]     s_awprot;
  logic           s_wvalid, s_wready;
  logic [31:0]    s_wdata;
  logic [3:0]     s_wstrb;
  logic           s_bvalid, s_bready;
  logic           s_arvalid, s_arready;
  logic [31:0]    s_araddr;
  logic [2:0]     s_arprot;
  logic           s_rvalid, s_rready;
  logic [31:0]    s_rdata;
  logic [32*N-1:0] regs_q;
  logic [N-1:0]   wr_pulse;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] mdl [N];

  always #5 clk = ~clk;

  axi_lite_reg_slave #(.NREGS(N), .RESET_VAL(RV)) dut (
    .clk(clk), .resetn(resetn),
    .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_awaddr(s_awaddr), .s_awprot(s_awprot),
    .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_araddr(s_araddr), .s_arprot(s_arprot),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_rdata(s_rdata), .regs_q(regs_q), .wr_pulse(wr_pulse)
  );

  task automatic check(input string tag, input logic [255:0] got,
                       input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] mdl_vec();
    logic [255:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[32*i +: 32] = mdl[i];
    return v;
  endfunction

  function automatic logic [31:0] mdl_read(input logic [31:0] a);
    int ix;
    ix = int'(a[9:2]);
    return (ix < N) ? mdl[ix] : 32'hDEAD_BEEF;
  endfunction

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_dly,
                           input int w_dly, input int b_dly);
    bit aw_done, w_done, aw_fire, w_fire;
    int cyc, lat, ix;
    logic [7:0] pmask;
    aw_done = 0; w_done = 0; cyc = 0; lat = 0;
    ix = int'(addr[9:2]);
    pmask = (ix < N && strb != 0) ? 8'(1 << ix) : 8'h00;
    s_awaddr = addr; s_awprot = 3'($urandom);
    s_wdata = data; s_wstrb = strb;
    while (!(aw_done && w_done) && cyc < 40) begin
      s_awvalid = !aw_done && cyc >= aw_dly;
      s_wvalid  = !w_done && cyc >= w_dly;
      @(negedge clk);
      if (aw_done) check("awready_held", 256'(s_awready), 256'(0));
      if (w_done) check("wready_held", 256'(s_wready), 256'(0));
      aw_fire = s_awvalid && s_awready;
      w_fire  = s_wvalid && s_wready;
      @(posedge clk); #1;
      aw_done |= aw_fire;
      w_done  |= w_fire;
      cyc++;
    end
    s_awvalid = 0; s_wvalid = 0;
    check("wr_accept", 256'({aw_done, w_done}), 256'(2'b11));
    while (lat < 10) begin
      @(negedge clk);
      if (s_bvalid) break;
      @(posedge clk); #1;
      lat++;
    end
    check("b_latency", 256'(lat), 256'(1));
    check("wr_pulse", 256'(wr_pulse), 256'(pmask));
    check("aw_blocked", 256'({s_awready, s_wready}), 256'(0));
    for (int k = 0; k < b_dly; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("b_hold", 256'(s_bvalid), 256'(1));
      check("pulse_once", 256'(wr_pulse), 256'(0));
      check("aw_blocked", 256'({s_awready, s_wready}), 256'(0));
    end
    @(posedge clk); #1;
    s_bready = 1;
    @(posedge clk); #1;
    s_bready = 0;
    @(negedge clk);
    check("b_done", 256'(s_bvalid), 256'(0));
    check("aw_reopen", 256'({s_awready, s_wready}), 256'(2'b11));
    check("pulse_clear", 256'(wr_pulse), 256'(0));
    if (ix < N) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) mdl[ix][8*b +: 8] = data[8*b +: 8];
    end
    check("regs_q", regs_q, mdl_vec());
    @(posedge clk); #1;
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [31:0] exp,
                          input int ar_dly, input int rr_dly);
    bit done, fire;
    int cyc, lat, want_lat;
    done = 0; cyc = 0; lat = 0;
`ifdef AXI_LITE_REG_SLAVE_RD_PIPE_EN
    want_lat = 1;
`else
    want_lat = 0;
`endif
    s_araddr = addr; s_arprot = 3'($urandom);
    while (!done && cyc < 40) begin
      s_arvalid = cyc >= ar_dly;
      @(negedge clk);
      fire = s_arvalid && s_arready;
      @(posedge clk); #1;
      done = fire;
      cyc++;
    end
    s_arvalid = 0;
    check("rd_accept", 256'(done), 256'(1));
    while (lat < 10) begin
      @(negedge clk);
      if (s_rvalid) break;
      @(posedge clk); #1;
      lat++;
    end
    check("r_latency", 256'(lat), 256'(want_lat));
    check("rdata", 256'(s_rdata), 256'(exp));
    check("ar_blocked", 256'(s_arready), 256'(0));
    for (int k = 0; k < rr_dly; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("r_hold", 256'({s_rvalid, s_rdata}), 256'({1'b1, exp}));
    end
    @(posedge clk); #1;
    s_rready = 1;
    @(posedge clk); #1;
    s_rready = 0;
    @(negedge clk);
    check("r_done", 256'(s_rvalid), 256'(0));
    check("ar_reopen", 256'(s_arready), 256'(1));
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] a;
    resetn = 0;
    s_awvalid = 0; s_awaddr = 0; s_awprot = 0;
    s_wvalid = 0; s_wdata = 0; s_wstrb = 0; s_bready = 0;
    s_arvalid = 0; s_araddr = 0; s_arprot = 0; s_rready = 0;
    for (int i = 0; i < N; i++) mdl[i] = RV;
    #12;
    check("rst_out", 256'({s_awready, s_wready, s_arready, s_bvalid,
                            s_rvalid, s_rdata, wr_pulse}), 256'(0));
    check("rst_regs", regs_q, mdl_vec());
    @(negedge clk);
    resetn = 1;
    @(posedge clk); #1;
    check("post_rst_rdy", 256'({s_awready, s_wready, s_arready}), 256'(3'b111));

    axi_write(32'h4, 32'h1234_5678, 4'hF, 0, 0, 0);
    check("same_cycle_reg1", 256'(regs_q[63:32]), 256'(32'h1234_5678));
    axi_write(32'h8, 32'hAAAA_BBBB, 4'h3, 3, 0, 0);
    check("w_first_reg2", 256'(regs_q[95:64]), 256'(32'h0000_BBBB));
    axi_write(32'hC, 32'hCAFE_F00D, 4'hF, 0, 0, 5);
    axi_read(32'h3FC, 32'hDEAD_BEEF, 0, 0);
    axi_write(32'h3FC, 32'h5555_AAAA, 4'hF, 0, 0, 0);
    axi_write(32'h10, 32'h7777_7777, 4'h0, 1, 0, 1);
    axi_write(32'h0, 32'h11, 4'hF, 0, 0, 0);
    fork
      axi_write(32'h0, 32'h22, 4'hF, 0, 0, 0);
      axi_read(32'h0, 32'h11, 1, 3);
    join
    axi_read(32'h0, 32'h22, 0, 0);

    for (int it = 0; it < 40; it++) begin
      a = ($urandom & 32'hFFFF_FC03) | (32'($urandom_range(0, N + 3)) << 2);
      if ($urandom_range(0, 1) == 1)
        axi_write(a, $urandom, 4'($urandom), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 3));
      else
        axi_read(a, mdl_read(a), $urandom_range(0, 2), $urandom_range(0, 3));
    end

    s_awaddr = 32'h8; s_awvalid = 1;
    @(negedge clk);
    @(posedge clk); #1;
    s_awvalid = 0;
    s_wvalid = 1; s_wdata = 32'h9999_9999; s_wstrb = 4'hF;
    resetn = 0;
    #1;
    for (int i = 0; i < N; i++) mdl[i] = RV;
    check("async_rst_out", 256'({s_awready, s_wready, s_arready, s_bvalid,
                                  s_rvalid, s_rdata, wr_pulse}), 256'(0));
    check("async_rst_regs", regs_q, mdl_vec());
    @(posedge clk); #1;
    s_wvalid = 0;
    @(negedge clk);
    resetn = 1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("no_b_after_rst", 256'(s_bvalid), 256'(0));
      check("rdy_after_rst", 256'({s_awready, s_wready}), 256'(2'b11));
    end
    check("regs_after_rst", regs_q, mdl_vec());
    @(posedge clk); #1;
    axi_read(32'h8, RV, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
